// File: rtl/rsa_pkg.sv
// Shared types and constants for the serial RSA modular multiplier.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StDbl,
    StAdd,
    StDone
  } rsa_state_e;

  // The accumulator needs one guard bit: doubled or summed values stay below 2*M.
  function automatic int unsigned acc_width(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/rsa_cond_sub.sv
// Single conditional subtraction of the modulus: y = (x >= m) ? x - m : x, truncated to WIDTH.
module rsa_cond_sub
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH:0]   x_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] y_o
);

  localparam int unsigned AccW = acc_width(WIDTH);

  logic [AccW-1:0] m_ext;

  always_comb begin
    m_ext = {1'b0, m_i};
    y_o   = (x_i >= m_ext) ? WIDTH'(x_i - m_ext) : x_i[WIDTH-1:0];
  end

endmodule

// File: rtl/rsa_modmul_serial.sv
// Interleaved MSB-first modular multiplier P = (A * B) mod M.
// Define RSA_MODMUL_SKIP_ZERO_EN to skip the ADD cycle for zero bits of B.
module rsa_modmul_serial
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int unsigned AccW = acc_width(WIDTH);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

  rsa_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             ready_q, ready_d, done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0] addend, red;
  logic [AccW-1:0]  sum;
  logic             bit_set;

  // DBL and ADD share one adder: doubling is acc + acc.
  always_comb begin
    addend  = (state_q == StDbl) ? acc_q : a_q;
    sum     = {1'b0, acc_q} + {1'b0, addend};
    bit_set = b_q[idx_q];
  end

  rsa_cond_sub #(
    .WIDTH(WIDTH)
  ) u_cond_sub (
    .x_i(sum),
    .m_i(m_q),
    .y_o(red)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d   = a_i;
          b_d   = b_i;
          m_d   = m_i;
          acc_d = '0;
          idx_d = IdxMax;
          err_d = 1'b0;
          if (m_i == '0 || a_i >= m_i) begin
            state_d = StDone;
            err_d   = 1'b1;
            p_d     = '0;
          end else begin
            state_d = StDbl;
          end
        end
      end
      StDbl: begin
        acc_d = red;
`ifdef RSA_MODMUL_SKIP_ZERO_EN
        if (!bit_set) begin
          if (idx_q == '0) begin
            state_d = StDone;
            p_d     = red;
          end else begin
            idx_d   = idx_q - IdxW'(1);
            state_d = StDbl;
          end
        end else begin
          state_d = StAdd;
        end
`else
        state_d = StAdd;
`endif
      end
      StAdd: begin
        if (bit_set) acc_d = red;
        if (idx_q == '0) begin
          state_d = StDone;
          p_d     = bit_set ? red : acc_q;
        end else begin
          idx_d   = idx_q - IdxW'(1);
          state_d = StDbl;
        end
      end
      StDone: state_d = StIdle;
    endcase
    done_d  = (state_d == StDone);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign p_o     = p_q;

endmodule

// File: tb/tb_rsa_modmul_serial.sv
// Scoreboard bench for rsa_modmul_serial; latency model follows RSA_MODMUL_SKIP_ZERO_EN.
module tb_rsa_modmul_serial;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [W-1:0] a_i, b_i, m_i, p_o;
  logic         ready_o, done_o, err_o;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned p;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsa_modmul_serial #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .m_i    (m_i),
    .ready_o(ready_o),
    .done_o (done_o),
    .err_o  (err_o),
    .p_o    (p_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned m);
    exp_t e;
    if (m == 0 || a >= m) begin
      e.p   = 0;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.p   = (a * b) % m;
      e.err = 1'b0;
`ifdef RSA_MODMUL_SKIP_ZERO_EN
      e.lat = W + $countones(b) + 1;
`else
      e.lat = 2 * W + 1;
`endif
    end
    return e;
  endfunction

  // glitch >= 0 pulses a stray start with junk operands that many cycles into the run.
  task automatic run_op(input int unsigned a, input int unsigned b, input int unsigned m,
                        input int glitch);
    exp_t e;
    int   t0;
    bit   seen;
    @(negedge clk);
    check("ready_idle", 32'(ready_o), 32'd1);
    a_i     = W'(a);
    b_i     = W'(b);
    m_i     = W'(m);
    start_i = 1'b1;
    t0      = cyc;
    sb.push_back(model(a, b, m));
    @(negedge clk);
    start_i = 1'b0;
    seen    = 1'b0;
    for (int k = 0; k < 4 * W; k++) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check("ready_busy", 32'(ready_o), 32'd0);
      start_i = (k == glitch);
      a_i     = W'($urandom);
      b_i     = W'($urandom);
      m_i     = W'($urandom);
      @(negedge clk);
    end
    start_i = 1'b0;
    e = sb.pop_front();
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(cyc - t0), 32'(e.lat));
      check("p_o", 32'(p_o), e.p);
      check("err_o", 32'(err_o), 32'(e.err));
      check("ready_in_done", 32'(ready_o), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(done_o), 32'd0);
      check("ready_after", 32'(ready_o), 32'd1);
      check("p_hold", 32'(p_o), e.p);
      check("err_hold", 32'(err_o), 32'(e.err));
    end
  endtask

  initial begin
    bit          seen;
    int unsigned ra, rb, rm;
    rst     = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    m_i     = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_p", 32'(p_o), 32'd0);
    rst = 1'b0;

    run_op(7, 9, 13, -1);
    run_op(200, 255, 251, -1);
    run_op(250, 255, 251, -1);
    run_op(13, 9, 13, -1);
    run_op(5, 9, 0, -1);
    run_op(7, 9, 13, -1);
    run_op(0, 255, 1, -1);
    run_op(0, 200, 97, -1);
    run_op(7, 9, 13, 3);
    run_op(5, 128, 11, -1);
    run_op(5, 255, 11, -1);
    run_op(254, 255, 255, -1);
    run_op(3, 0, 7, -1);

    // Abort a run six cycles after start.
    @(negedge clk);
    a_i     = 8'd7;
    b_i     = 8'd9;
    m_i     = 8'd13;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_err", 32'(err_o), 32'd0);
    check("abort_p", 32'(p_o), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(7, 9, 13, -1);

    for (int i = 0; i < 1000; i++) begin
      rm = $urandom_range(255, 1);
      ra = $urandom_range(rm - 1, 0);
      rb = $urandom_range(255, 0);
      run_op(ra, rb, rm, -1);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
